// File: rtl/carry_norm_if.sv
// Job-control and digit-stream handshake bundle for carry_norm_seq.
interface carry_norm_if #(
    parameter int W     = 32,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_coef;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_digit;
    logic             out_last;

    modport master (
        output start, len, in_valid, in_coef, out_ready,
        input  busy, done, err, in_ready, out_valid, out_digit, out_last
    );

    modport slave (
        input  start, len, in_valid, in_coef, out_ready,
        output busy, done, err, in_ready, out_valid, out_digit, out_last
    );
endinterface

// File: rtl/carry_norm_seq.sv
// Turns convolution coefficients (LSB first) into a base-10 digit stream,
// flushing the residual carry as extra digits after the last coefficient.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one digit per accepted coefficient
// FLUSH | emitting remaining carry digits
// DONE  | waiting for the out_last digit to be taken, then pulse done
module carry_norm_seq #(
    parameter int W     = 32,
    parameter int LEN_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    carry_norm_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [W:0] TEN = {{(W-3){1'b0}}, 4'd10};

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [W-1:0]     carry_q;
    logic             err_q;
    logic             busy_q;
    logic             done_q;
    logic             out_valid_q;
    logic [3:0]       out_digit_q;
    logic             out_last_q;

    logic             coef_neg;
    logic [W-1:0]     coef_pos;
    logic [W:0]       sum_d;
    logic [W-1:0]     carry_d;
    logic [3:0]       digit_d;
    logic             out_free;
    logic             out_fire;
    logic             in_rdy;
    logic             in_fire;

    // Negative coefficients clamp to zero; FLUSH reuses the divider on carry alone.
    always_comb begin
        coef_neg = bus.in_coef[W-1];
        coef_pos = coef_neg ? '0 : bus.in_coef;
        sum_d    = (state_q == FLUSH) ? {1'b0, carry_q}
                                      : {1'b0, coef_pos} + {1'b0, carry_q};
        carry_d  = W'(sum_d / TEN);
        digit_d  = 4'(sum_d % TEN);
    end

    assign out_free = !out_valid_q || bus.out_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    assign in_rdy   = (state_q == RUN) && out_free;
    assign in_fire  = bus.in_valid && in_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            carry_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_digit_q <= 4'd0;
            out_last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (out_fire) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        len_q   <= bus.len;
                        carry_q <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (bus.len == '0) begin
                            out_valid_q <= 1'b1;
                            out_digit_q <= 4'd0;
                            out_last_q  <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        out_valid_q <= 1'b1;
                        out_digit_q <= digit_d;
                        carry_q     <= carry_d;
                        len_q       <= len_q - LEN_W'(1);
                        out_last_q  <= 1'b0;
                        if (coef_neg) err_q <= 1'b1;
                        if (len_q == LEN_W'(1)) begin
                            if (carry_d == '0) begin
                                out_last_q <= 1'b1;
                                state_q    <= DONE;
                            end else begin
                                state_q <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        out_valid_q <= 1'b1;
                        out_digit_q <= digit_d;
                        carry_q     <= carry_d;
                        out_last_q  <= (carry_d == '0);
                        if (carry_d == '0) state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_fire && out_last_q) begin
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        out_last_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_digit = out_digit_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_carry_norm_seq.sv
// Self-checking bench for carry_norm_seq: job table plus scoreboard of expected digits.
module tb_carry_norm_seq;
    logic clk;
    logic rst;

    carry_norm_if #(.W(32), .LEN_W(8)) bus ();

    carry_norm_seq #(.W(32), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int len;
        int coef[4];
        int n_dig;
        int dig[11];
        bit exp_err;
        bit stall;
        bit poke;
    } vec_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   last_pop_cyc = -10;
    bit   stall_en = 0;
    bit   mon_en   = 1;
    bit   stall_prev = 0;
    logic [3:0] hold_d;
    logic hold_l;
    int   exp_q[$];
    vec_t vecs[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic fail_wait(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: wait expired, got no event, required one", name);
    endtask

    // out_ready pattern 1,0,0,1,0,0... when stalling is enabled
    always @(posedge clk) begin
        #1;
        cyc++;
        bus.out_ready = stall_en ? (cyc % 3 == 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_digit", bus.out_digit, hold_d);
                chk("hold_last", bus.out_last, hold_l);
            end
            if (bus.out_valid && !bus.out_ready)
                chk("stall_in_ready", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL extra_digit: got digit %0d, required none", bus.out_digit);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("digit", bus.out_digit, e % 16);
                    chk("last", bus.out_last, e / 16);
                    if (e / 16 == 1) last_pop_cyc = cyc;
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_digit;
            hold_l = bus.out_last;
        end
    end

    function automatic vec_t model(input vec_t v);
        longint c;
        longint s;
        c = 0;
        v.n_dig = 0;
        for (int i = 0; i < v.len; i++) begin
            s = ((v.coef[i] < 0) ? 0 : longint'(v.coef[i])) + c;
            v.dig[v.n_dig] = int'(s % 10);
            v.n_dig = v.n_dig + 1;
            c = s / 10;
        end
        while (c != 0) begin
            v.dig[v.n_dig] = int'(c % 10);
            v.n_dig = v.n_dig + 1;
            c = c / 10;
        end
        if (v.len == 0) begin
            v.dig[0] = 0;
            v.n_dig = 1;
        end
        return v;
    endfunction

    task automatic feed(input vec_t v, input int count);
        bit hs;
        int guard;
        for (int i = 0; i < count; i++) begin
            hs = 0;
            guard = 0;
            bus.in_valid = 1'b1;
            bus.in_coef  = 32'(v.coef[i]);
            if (v.poke && i == 1) begin
                bus.start = 1'b1;
                bus.len   = 8'd0;
            end
            while (!hs && guard < 100) begin
                @(negedge clk);
                hs = bus.in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            bus.start = 1'b0;
            if (!hs) fail_wait("in_handshake");
            if (i == 0) chk("latency", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        bit got;
        stall_en = v.stall;
        for (int j = 0; j < v.n_dig; j++)
            exp_q.push_back(v.dig[j] + ((j == v.n_dig - 1) ? 16 : 0));
        bus.start = 1'b1;
        bus.len   = 8'(v.len);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        chk("err_cleared", bus.err, 0);
        chk("in_ready_after_start", bus.in_ready, v.len != 0);
        feed(v, v.len);
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (v.len == 0) chk("len0_in_ready", bus.in_ready, 0);
            if (bus.done) got = 1;
        end
        if (!got) begin
            fail_wait("done");
        end else begin
            chk("busy_with_done", bus.busy, 0);
            chk("done_timing", cyc, last_pop_cyc + 1);
            chk("err", bus.err, v.exp_err);
            chk("digits_left", exp_q.size(), 0);
            @(negedge clk);
            chk("done_pulse_width", bus.done, 0);
        end
        exp_q.delete();
        stall_en = 0;
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{len:3, coef:'{7, 15, 9, 0}, n_dig:4, dig:'{7,5,0,1,0,0,0,0,0,0,0},
                    exp_err:0, stall:0, poke:1};
        vecs[1] = '{len:1, coef:'{2147483647, 0, 0, 0}, n_dig:10, dig:'{7,4,6,3,8,4,7,4,1,2,0},
                    exp_err:0, stall:0, poke:0};
        vecs[2] = '{len:4, coef:'{9, 9, 9, 9}, n_dig:4, dig:'{9,9,9,9,0,0,0,0,0,0,0},
                    exp_err:0, stall:1, poke:0};
        vecs[3] = '{len:0, coef:'{0, 0, 0, 0}, n_dig:1, dig:'{0,0,0,0,0,0,0,0,0,0,0},
                    exp_err:0, stall:0, poke:0};
        vecs[4] = '{len:2, coef:'{-5, 23, 0, 0}, n_dig:3, dig:'{0,3,2,0,0,0,0,0,0,0,0},
                    exp_err:1, stall:0, poke:0};
        vecs[5] = '{len:1, coef:'{4, 0, 0, 0}, n_dig:1, dig:'{4,0,0,0,0,0,0,0,0,0,0},
                    exp_err:0, stall:0, poke:0};
        vecs[6] = '{len:3, coef:'{99, 99, 99, 0}, n_dig:5, dig:'{9,8,9,0,1,0,0,0,0,0,0},
                    exp_err:0, stall:1, poke:0};
        vecs[7] = '{len:2, coef:'{0, 0, 0, 0}, n_dig:2, dig:'{0,0,0,0,0,0,0,0,0,0,0},
                    exp_err:0, stall:0, poke:0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.len = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_coef = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_digit", bus.out_digit, 0);
        chk("rst_out_last", bus.out_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_job(vecs[0]);
        run_job(vecs[1]);
        run_job(vecs[2]);
        run_job(vecs[3]);
        run_job(vecs[4]);
        run_job(vecs[6]);
        run_job(vecs[7]);

        // Reset in the middle of a five-coefficient job
        mon_en = 0;
        rv = '{len:5, coef:'{1, 2, 3, 4}, n_dig:0, dig:'{0,0,0,0,0,0,0,0,0,0,0},
               exp_err:0, stall:0, poke:0};
        bus.start = 1'b1;
        bus.len = 8'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        feed(rv, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_err", bus.err, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_digit", bus.out_digit, 0);
        chk("mid_rst_out_last", bus.out_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1;
        run_job(vecs[5]);

        for (int r = 0; r < 3; r++) begin
            rv.len = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) rv.coef[i] = int'($urandom_range(0, 999999));
            rv.exp_err = 0;
            rv.stall = (r == 1);
            rv.poke = 0;
            rv = model(rv);
            run_job(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
